// File: rtl/cic_pkg.sv
// ============================================================================
//  Module      : cic_pkg
//  Description : Shared definitions for the variable-rate CIC interpolator and
//                decimator: stage mode, supported-rate list, per-rate output
//                shift, accumulator width check and round-and-saturate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cic_pkg;

  // Stage flavour for cic_accum_stage.
  typedef enum logic {
    CIC_COMB  = 1'b0,
    CIC_INTEG = 1'b1
  } cic_mode_e;

  // Widest accumulator the scaling helper can take.
  localparam int CIC_MAX_WIDTH = 64;

  // Largest output shift in the table (R = 40); sizes the ACC headroom check.
  localparam int CIC_MAX_SHIFT = 22;

  // True for the rates the filter supports; anything else parks the block.
  function automatic logic rate_supported(input logic [5:0] rate);
    case (rate)
      6'd2, 6'd4, 6'd8, 6'd16, 6'd32,
      6'd5, 6'd10, 6'd20, 6'd40: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Output shift = ceil(4*log2(R)), so DC gain R^4 / 2^shift never exceeds 1.
  function automatic logic [4:0] rate_shift(input logic [5:0] rate);
    case (rate)
      6'd2:    return 5'd4;
      6'd4:    return 5'd8;
      6'd8:    return 5'd12;
      6'd16:   return 5'd16;
      6'd32:   return 5'd20;
      6'd5:    return 5'd10;
      6'd10:   return 5'd14;
      6'd20:   return 5'd18;
      6'd40:   return 5'd22;
      default: return 5'd0;
    endcase
  endfunction

  // Accumulators must hold the input plus the worst-case filter growth.
  function automatic bit acc_width_ok(input int acc_w, input int in_w, input int stages);
    return acc_w >= in_w + CIC_MAX_SHIFT + stages;
  endfunction

  // Round-half-up at bit 'shift', then clamp into a signed out_width range.
  // The result is returned sign-extended to 64 bits; the caller truncates.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input logic        [4:0]  shift,
    input int                 out_width
  );
    logic signed [63:0] shifted;
    logic signed [63:0] rbit;
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic        [5:0]  idx;
    shifted = acc >>> shift;
    idx     = {1'b0, shift} - 6'd1;
    rbit    = '0;
    if (shift != 5'd0) begin
      rbit[0] = acc[idx];
    end
    rounded = shifted + rbit;
    max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_width - 1));
    if (rounded > max_v) begin
      return max_v;
    end else if (rounded < min_v) begin
      return min_v;
    end
    return rounded;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_accum_stage.sv
// ============================================================================
//  Module      : cic_accum_stage
//  Description : One registered CIC stage. COMB mode: y = x - x_prev.
//                INTEG mode: y = y + x. Updates only while enable is high;
//                arithmetic wraps modulo 2^WIDTH.
//  Ports       : clock    - system clock
//                reset_n  - synchronous active-low reset (clears all state)
//                enable   - stage update strobe
//                in_data  - signed stage input
//                out_data - signed registered stage output
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_accum_stage
  import cic_pkg::*;
#(
  parameter int        WIDTH = 48,
  parameter cic_mode_e MODE  = CIC_COMB
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0] out_data
);

  if (MODE == CIC_COMB) begin : g_comb
    logic signed [WIDTH-1:0] prev;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        prev     <= '0;
        out_data <= '0;
      end else if (enable) begin
        prev     <= in_data;
        out_data <= in_data - prev;
      end
    end
  end else begin : g_integ
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        out_data <= '0;
      end else if (enable) begin
        out_data <= out_data + in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/varcic_interp.sv
// ============================================================================
//  Module      : varcic_interp
//  Description : Variable-rate CIC interpolator (TX path). Takes low-rate
//                signed samples, zero-stuffs them by R, filters through
//                STAGES comb + STAGES integrator stages and scales the result
//                by 2^-shift(R) with rounding and saturation.
//  Ports       : clock         - system clock
//                reset_n       - synchronous active-low reset
//                interpolation - requested rate R (2,4,8,16,32,5,10,20,40)
//                out_ce        - high-rate clock enable from downstream
//                in_data       - low-rate sample, held until in_req
//                in_req        - pulse: in_data consumed, present the next
//                out_data      - scaled high-rate sample
//                out_strobe    - pulse: out_data updated
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module varcic_interp
  import cic_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [5:0]                  interpolation,
  input  logic                        out_ce,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        in_req,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_strobe
);

  if (!acc_width_ok(ACC_WIDTH, IN_WIDTH, STAGES) || (ACC_WIDTH > CIC_MAX_WIDTH)) begin : g_width_check
    $error("varcic_interp: ACC_WIDTH too small for IN_WIDTH/STAGES or wider than 64");
  end

  logic [5:0] rate_q;
  logic [4:0] shift_q;
  logic [5:0] phase;
  logic       active;
  logic       ce_act;
  logic       load;

  logic signed [ACC_WIDTH-1:0] comb_d  [STAGES+1];
  logic signed [ACC_WIDTH-1:0] integ_d [STAGES+1];

  // An unsupported latched rate parks the whole datapath.
  assign active = rate_supported(rate_q);
  assign ce_act = out_ce & active;
  assign load   = ce_act & (phase == 6'd0);

  // Rate/shift relatch only at a frame boundary, so a new rate never splits
  // a frame. While parked, keep sampling so a valid rate restarts promptly.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rate_q  <= interpolation;
      shift_q <= rate_shift(interpolation);
    end else if (load || !active) begin
      rate_q  <= interpolation;
      shift_q <= rate_shift(interpolation);
    end
  end

  // Phase counts high-rate samples within one low-rate frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (!active) begin
      phase <= '0;
    end else if (ce_act) begin
      phase <= (phase == rate_q - 6'd1) ? 6'd0 : phase + 6'd1;
    end
  end

  assign comb_d[0] = ACC_WIDTH'(in_data);

  // Zero-stuffing: the comb result registered at phase 0 enters the
  // integrators exactly once per frame, on the following high-rate slot.
  assign integ_d[0] = (phase == 6'd1) ? comb_d[STAGES] : '0;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cic_accum_stage #(
      .WIDTH (ACC_WIDTH),
      .MODE  (CIC_COMB)
    ) u_comb (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (load),
      .in_data  (comb_d[i]),
      .out_data (comb_d[i+1])
    );

    cic_accum_stage #(
      .WIDTH (ACC_WIDTH),
      .MODE  (CIC_INTEG)
    ) u_integ (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (ce_act),
      .in_data  (integ_d[i]),
      .out_data (integ_d[i+1])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_req     <= 1'b0;
      out_strobe <= 1'b0;
      out_data   <= '0;
    end else begin
      in_req     <= load;
      out_strobe <= ce_act;
      if (!active) begin
        out_data <= '0;
      end else if (ce_act) begin
        out_data <= OUT_WIDTH'(sat_round(CIC_MAX_WIDTH'(integ_d[STAGES]), shift_q, OUT_WIDTH));
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_varcic_interp.sv
// ============================================================================
//  Module      : tb_varcic_interp
//  Description : Self-checking bench for varcic_interp. DC gain table across
//                all rates, impulse response, rate change / idle handling and
//                a mid-stream reset compared against a convolution model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_varcic_interp;

  localparam int STAGES    = 5;
  localparam int IN_WIDTH  = 16;
  localparam int ACC_WIDTH = 48;
  localparam int OUT_WIDTH = 16;
  localparam int NOUT      = 100;
  localparam int NSEQ      = 40;

  logic                        clock         = 1'b0;
  logic                        reset_n       = 1'b0;
  logic [5:0]                  interpolation = 6'd16;
  logic                        out_ce        = 1'b0;
  logic signed [IN_WIDTH-1:0]  in_data       = '0;
  logic                        in_req;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_strobe;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  varcic_interp #(
    .STAGES    (STAGES),
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .interpolation (interpolation),
    .out_ce        (out_ce),
    .in_data       (in_data),
    .in_req        (in_req),
    .out_data      (out_data),
    .out_strobe    (out_strobe)
  );

  typedef struct {
    int rate;
    int din;
    int want;
  } dc_vec_t;

  dc_vec_t dc [11];
  int      seq [NSEQ];
  longint  h [256];
  int      hlen;
  longint  model_out [NOUT];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic do_reset(input int r, input int din);
    reset_n       = 1'b0;
    out_ce        = 1'b0;
    interpolation = 6'(r);
    in_data       = 16'(din);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_until_req(input int max_ticks, output int ces, output bit got);
    ces = 0;
    got = 1'b0;
    while (!got && ces < max_ticks) begin
      out_ce = 1'b1;
      tick();
      ces++;
      if (in_req) got = 1'b1;
    end
  endtask

  function automatic int ref_shift(input int r);
    case (r)
      2:  return 4;
      4:  return 8;
      8:  return 12;
      16: return 16;
      32: return 20;
      5:  return 10;
      10: return 14;
      20: return 18;
      40: return 22;
      default: return 0;
    endcase
  endfunction

  function automatic longint scale(input longint y, input int s);
    longint r;
    r = (y + (longint'(1) <<< (s - 1))) >>> s;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Impulse response of the whole interpolator: (1 + z^-1 + ... + z^-(R-1))^STAGES.
  task automatic build_h(input int r);
    longint t [256];
    for (int i = 0; i < 256; i++) h[i] = 0;
    h[0] = 1;
    hlen = 1;
    for (int st = 0; st < STAGES; st++) begin
      for (int i = 0; i < 256; i++) t[i] = 0;
      for (int i = 0; i < hlen; i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      hlen += r - 1;
      for (int i = 0; i < 256; i++) h[i] = t[i];
    end
  endtask

  // Output n (counted in out_ce since reset) is the zero-stuffed input
  // convolved with h, delayed by 4 frames of comb pipeline plus 6 slots.
  task automatic build_model(input int r);
    longint y;
    int     m;
    build_h(r);
    for (int n = 0; n < NOUT; n++) begin
      m = n - 6 - 4 * r;
      y = 0;
      if (m >= 0) begin
        for (int j = 0; j < hlen && j <= m; j++)
          if (((m - j) % r) == 0) y += h[j] * longint'(seq[(m - j) / r]);
      end
      model_out[n] = (m >= 0) ? scale(y, ref_shift(r)) : 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int  reqs;
    int  strobes;
    int  n;
    bit  got;
    int  nz;
    longint sum;
    longint imp [6];
    longint imp_want [6];
    int  idx;
    bit  ce;

    dc[0]  = '{16,   1000,   1000};
    dc[1]  = '{5,    1000,    610};
    dc[2]  = '{2,    -500,   -500};
    dc[3]  = '{8,   -1000,  -1000};
    dc[4]  = '{4,     300,    300};
    dc[5]  = '{10,   1000,    610};
    dc[6]  = '{20,   1000,    610};
    dc[7]  = '{40,   1000,    610};
    dc[8]  = '{5,   -1000,   -610};
    dc[9]  = '{32,  32767,  32767};
    dc[10] = '{32, -32768, -32768};

    for (int k = 0; k < NSEQ; k++) seq[k] = ((k * 7919 + 13) % 2001) - 1000;

    imp_want[0] = 1;  imp_want[1] = 5;  imp_want[2] = 10;
    imp_want[3] = 10; imp_want[4] = 5;  imp_want[5] = 1;

    // Reset state with out_ce and data active.
    reset_n = 1'b0;
    out_ce  = 1'b1;
    in_data = 16'sd1000;
    tick();
    tick();
    check("reset_out_data", out_data, 0);
    check("reset_out_strobe", out_strobe, 0);
    check("reset_in_req", in_req, 0);

    // DC gain table, continuous out_ce.
    for (int v = 0; v < 11; v++) begin
      do_reset(dc[v].rate, dc[v].din);
      for (int c = 0; c < 10 * dc[v].rate + 20; c++) begin
        out_ce = 1'b1;
        tick();
      end
      reqs = 0;
      for (int c = 0; c < 2 * dc[v].rate; c++) begin
        out_ce = 1'b1;
        tick();
        check($sformatf("dc_r%0d_d%0d_out", dc[v].rate, dc[v].din), out_data, dc[v].want);
        if (in_req) reqs++;
      end
      check($sformatf("dc_r%0d_req_count", dc[v].rate), reqs, 2);
    end

    // R=2 impulse of 16 followed by zeros.
    do_reset(2, 16);
    nz  = 0;
    sum = 0;
    for (int c = 0; c < 60; c++) begin
      out_ce = 1'b1;
      tick();
      if (in_req) in_data = '0;
      if (out_data != 0) begin
        if (nz < 6) imp[nz] = out_data;
        nz++;
        sum += out_data;
      end
    end
    check("impulse_nonzero_count", nz, 6);
    check("impulse_sum", sum, 32);
    if (nz == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("impulse_tap%0d", i), imp[i], imp_want[i]);
    end

    // Rate change 8 -> 4 mid-frame, then unsupported rate 7, then resume.
    do_reset(8, 1000);
    for (int c = 0; c < 100; c++) begin
      out_ce = 1'b1;
      tick();
    end
    run_until_req(20, n, got);
    check("rate_sync_req", got, 1);
    for (int c = 0; c < 3; c++) begin
      out_ce = 1'b1;
      tick();
    end
    interpolation = 6'd4;
    run_until_req(20, n, got);
    check("rate_old_spacing", n + 3, 8);
    run_until_req(20, n, got);
    check("rate_new_spacing", n, 4);
    run_until_req(20, n, got);
    check("rate_new_spacing2", n, 4);
    out_ce = 1'b1;
    tick();
    interpolation = 6'd7;
    run_until_req(20, n, got);
    check("rate_last_load_spacing", n + 1, 4);
    reqs    = 0;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      out_ce = 1'b1;
      tick();
      if (in_req) reqs++;
      if (out_strobe) strobes++;
    end
    check("idle_in_req", reqs, 0);
    check("idle_out_strobe", strobes, 0);
    check("idle_out_data", out_data, 0);
    interpolation = 6'd16;
    run_until_req(5, n, got);
    check("idle_resume_req", got, 1);

    // Streaming with random out_ce gaps, mid-run reset, restart vs model.
    build_model(5);
    do_reset(5, seq[0]);
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      out_ce = ($urandom_range(0, 3) != 0);
      tick();
      if (in_req) begin
        idx++;
        in_data = 16'(seq[idx]);
      end
    end
    reset_n = 1'b0;
    out_ce  = 1'b1;
    in_data = 16'(seq[0]);
    tick();
    reset_n = 1'b1;
    check("midreset_out_data", out_data, 0);
    check("midreset_out_strobe", out_strobe, 0);
    check("midreset_in_req", in_req, 0);
    idx = 0;
    n   = 0;
    for (int c = 0; c < 400 && n < NOUT; c++) begin
      ce     = ($urandom_range(0, 3) != 0);
      out_ce = ce;
      tick();
      if (ce) begin
        check($sformatf("restart_strobe_n%0d", n), out_strobe, 1);
        check($sformatf("restart_out_n%0d", n), out_data, model_out[n]);
        n++;
      end else begin
        check("gap_strobe_low", out_strobe, 0);
      end
      if (in_req) begin
        idx++;
        in_data = (idx < NSEQ) ? 16'(seq[idx]) : '0;
      end
    end
    check("restart_output_count", n, NOUT);

    out_ce = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
